// File: rtl/mips_mc_pkg.sv
// Shared types for the multicycle MIPS core: FSM state encoding, opcode/funct
// constants and the small ALU used by the EXEC state.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_ADDIEX = 4'd9,
      ST_ADDIWB = 4'd10,
      ST_JUMP   = 4'd11,
      ST_TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_t;

   function automatic logic funct_legal(input logic [5:0] funct);
      return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
   endfunction

   function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
      alu_op_t op;
      case (funct)
         FN_SUB:  op = ALU_SUB;
         FN_AND:  op = ALU_AND;
         FN_OR:   op = ALU_OR;
         FN_SLT:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] r;
      case (op)
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_SLT: r = {31'b0, ($signed(a) < $signed(b))};
         default: r = a + b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory port: one request at a time, completed by ready.
interface mips_multicycle_core_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_rdata, mem_ready);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_mc_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// register 0 reads as zero and ignores writes.
module mips_mc_regfile #(
   parameter int NREGS_LOG2 = 5
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREGS_LOG2-1:0] ra1_i,
   input  logic [NREGS_LOG2-1:0] ra2_i,
   output logic [31:0]           rd1_o,
   output logic [31:0]           rd2_o,
   input  logic                  we_i,
   input  logic [NREGS_LOG2-1:0] wa_i,
   input  logic [31:0]           wd_i
);
   localparam int NREGS = 1 << NREGS_LOG2;

   logic [31:0] regs_q [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (wa_i != '0)) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign rd1_o = (ra1_i == '0) ? 32'h0 : regs_q[ra1_i];
   assign rd2_o = (ra2_i == '0) ? 32'h0 : regs_q[ra2_i];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core (add/sub/and/or/slt, addi, lw, sw, beq, j) with a GPIO store
// register; defining MIPS_MC_BNE_EN adds bne, otherwise opcode 0x05 traps.
module mips_multicycle_core
   import mips_mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter int          GPIO_WIDTH = 8,
   parameter logic [31:0] GPIO_ADDR  = 32'h1001_0024,
   parameter int          NREGS_LOG2 = 5
)(
   input  logic                   clk,
   input  logic                   reset,
   mips_multicycle_core_if.master mem,
   output logic [GPIO_WIDTH-1:0]  gpio_o,
   output logic [3:0]             state_o,
   output logic                   trap_o,
   output logic [31:0]            result_o
);

   state_t state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
   logic [31:0] a_q, a_d, b_q, b_d, alu_q, alu_d;
   logic [GPIO_WIDTH-1:0] gpio_q, gpio_d;
   logic trap_q, trap_d;

   logic [5:0]  opcode, funct;
   logic [31:0] imm_sext;
   logic [NREGS_LOG2-1:0] rs_idx, rt_idx, rd_idx;
   logic [31:0] rf_rd1, rf_rd2, rf_wd;
   logic [NREGS_LOG2-1:0] rf_wa;
   logic rf_we, gpio_hit, branch_taken;
   logic req_c, we_c;
   logic [31:0] addr_c;
   alu_op_t alu_op;

   assign opcode   = ir_q[31:26];
   assign funct    = ir_q[5:0];
   assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
   assign rs_idx   = ir_q[21 +: NREGS_LOG2];
   assign rt_idx   = ir_q[16 +: NREGS_LOG2];
   assign rd_idx   = ir_q[11 +: NREGS_LOG2];
   assign alu_op   = funct_to_alu(funct);
   assign gpio_hit = (alu_q == GPIO_ADDR);

`ifdef MIPS_MC_BNE_EN
   assign branch_taken = (opcode == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
   assign branch_taken = (a_q == b_q);
`endif

   mips_mc_regfile #(.NREGS_LOG2(NREGS_LOG2)) u_regfile (
      .clk   (clk),
      .reset (reset),
      .ra1_i (rs_idx),
      .ra2_i (rt_idx),
      .rd1_o (rf_rd1),
      .rd2_o (rf_rd2),
      .we_i  (rf_we),
      .wa_i  (rf_wa),
      .wd_i  (rf_wd)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  if (mem.mem_ready) state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_d = ST_EXEC;
               OP_LW, OP_SW: state_d = ST_MEMADR;
               OP_BEQ:       state_d = ST_BRANCH;
`ifdef MIPS_MC_BNE_EN
               OP_BNE:       state_d = ST_BRANCH;
`endif
               OP_ADDI:      state_d = ST_ADDIEX;
               OP_J:         state_d = ST_JUMP;
               default:      state_d = ST_TRAP;
            endcase
         end
         ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:  if (mem.mem_ready) state_d = ST_MEMWB;
         ST_MEMWR:  if (gpio_hit || mem.mem_ready) state_d = ST_FETCH;
         ST_EXEC:   state_d = funct_legal(funct) ? ST_ALUWB : ST_TRAP;
         ST_ADDIEX: state_d = ST_ADDIWB;
         ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
         ST_TRAP:   state_d = ST_TRAP;
         default:   state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      req_c  = 1'b0;
      we_c   = 1'b0;
      addr_c = pc_q;
      rf_we  = 1'b0;
      rf_wa  = rt_idx;
      rf_wd  = alu_q;
      case (state_q)
         ST_FETCH: req_c = 1'b1;
         ST_MEMRD: begin
            req_c  = 1'b1;
            addr_c = alu_q;
         end
         ST_MEMWR: begin
            addr_c = alu_q;
            // A GPIO hit is absorbed locally and never reaches the bus.
            req_c  = !gpio_hit;
            we_c   = !gpio_hit;
         end
         ST_MEMWB: begin
            rf_we = 1'b1;
            rf_wd = mdr_q;
         end
         ST_ALUWB: begin
            rf_we = 1'b1;
            rf_wa = rd_idx;
         end
         ST_ADDIWB: rf_we = 1'b1;
         default: ;
      endcase
   end

   assign mem.mem_req   = req_c & ~reset;
   assign mem.mem_we    = we_c & ~reset;
   assign mem.mem_addr  = addr_c;
   assign mem.mem_wdata = b_q;

   always_comb begin
      pc_d   = pc_q;
      ir_d   = ir_q;
      mdr_d  = mdr_q;
      a_d    = a_q;
      b_d    = b_q;
      alu_d  = alu_q;
      gpio_d = gpio_q;
      trap_d = trap_q;
      case (state_q)
         ST_FETCH: begin
            if (mem.mem_ready) begin
               ir_d = mem.mem_rdata;
               pc_d = pc_q + 32'd4;
            end
         end
         ST_DECODE: begin
            a_d   = rf_rd1;
            b_d   = rf_rd2;
            alu_d = pc_q + {imm_sext[29:0], 2'b00};
         end
         ST_MEMADR, ST_ADDIEX: alu_d = a_q + imm_sext;
         ST_MEMRD: if (mem.mem_ready) mdr_d = mem.mem_rdata;
         ST_MEMWR: if (gpio_hit) gpio_d = b_q[GPIO_WIDTH-1:0];
         ST_EXEC:   alu_d = alu_eval(alu_op, a_q, b_q);
         ST_BRANCH: if (branch_taken) pc_d = alu_q;
         ST_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
         ST_TRAP:   trap_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         ir_q   <= '0;
         mdr_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         alu_q  <= '0;
         gpio_q <= '0;
         trap_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         ir_q   <= ir_d;
         mdr_q  <= mdr_d;
         a_q    <= a_d;
         b_q    <= b_d;
         alu_q  <= alu_d;
         gpio_q <= gpio_d;
         trap_q <= trap_d;
      end
   end

   assign gpio_o   = gpio_q;
   assign state_o  = state_q;
   assign trap_o   = trap_q;
   assign result_o = alu_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed and randomized checks of mips_multicycle_core against an
// instruction-level reference model with a variable-latency memory responder.
`timescale 1ns/1ps
module tb_mips_multicycle_core;

   localparam logic [31:0] RESET_PC  = 32'h0040_0000;
   localparam logic [31:0] GPIO_ADDR = 32'h1001_0024;
   localparam logic [31:0] DATA_BASE = 32'h1001_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  gpio;
   logic [3:0]  state;
   logic        trap;
   logic [31:0] result;

   mips_multicycle_core_if mif();

   mips_multicycle_core #(
      .RESET_PC   (RESET_PC),
      .GPIO_WIDTH (8),
      .GPIO_ADDR  (GPIO_ADDR),
      .NREGS_LOG2 (5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .mem      (mif),
      .gpio_o   (gpio),
      .state_o  (state),
      .trap_o   (trap),
      .result_o (result)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // bench memory and bus bookkeeping
   logic [31:0] mem [logic [31:0]];
   logic [63:0] stores [$];
   int          wait_n = 0;
   int          wcnt = 0;
   int          cyc = 0;
   int          gpio_bus_hits = 0;
   bit          prev_wait = 0;
   logic [31:0] prev_addr, prev_wdata;
   logic [3:0]  prev_state;

   // reference model state
   logic [31:0] mregs [32];
   logic [31:0] mmem [logic [31:0]];
   logic [63:0] mstores [$];
   logic [7:0]  mgpio;
   logic [31:0] malu;
   int          mcyc;
   bit          mtrap;

   logic [31:0] prog [$];
   logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
   int          ran;
   bit          reached;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] r_t(input int rs, input int rt, input int rd,
                                       input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic logic [31:0] i_t(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] j_t(input logic [31:0] target);
      return {6'h02, target[27:2]};
   endfunction

   // one clock cycle: answer the bus, then advance to the next falling edge
   task automatic tick();
      mif.mem_ready = 1'b0;
      mif.mem_rdata = 32'h0;
      if (mif.mem_req) begin
         if (mif.mem_we && (mif.mem_addr == GPIO_ADDR)) gpio_bus_hits++;
         if (prev_wait && (state == prev_state)) begin
            check("hold_addr", mif.mem_addr, prev_addr);
            if (mif.mem_we) check("hold_wdata", mif.mem_wdata, prev_wdata);
         end
         if (wcnt >= wait_n) begin
            mif.mem_ready = 1'b1;
            wcnt = 0;
            prev_wait = 0;
            if (mif.mem_we) begin
               mem[mif.mem_addr] = mif.mem_wdata;
               stores.push_back({mif.mem_addr, mif.mem_wdata});
            end else begin
               mif.mem_rdata = mem.exists(mif.mem_addr) ? mem[mif.mem_addr] : 32'h0;
            end
         end else begin
            wcnt++;
            prev_wait  = 1;
            prev_addr  = mif.mem_addr;
            prev_wdata = mif.mem_wdata;
            prev_state = state;
         end
      end else begin
         mif.mem_ready = 1'($urandom_range(0, 1));
         mif.mem_rdata = $urandom;
         wcnt = 0;
         prev_wait = 0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic release_reset();
      reset = 1'b0;
      #1;
      cyc = 0;
      wcnt = 0;
      prev_wait = 0;
      gpio_bus_hits = 0;
      stores.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      release_reset();
   endtask

   task automatic load_prog();
      mem.delete();
      mmem.delete();
      mem[32'h100] = GPIO_ADDR;
      mem[32'h104] = DATA_BASE;
      mmem[32'h100] = GPIO_ADDR;
      mmem[32'h104] = DATA_BASE;
      foreach (prog[i]) begin
         mem[RESET_PC + 32'(4 * i)]  = prog[i];
         mmem[RESET_PC + 32'(4 * i)] = prog[i];
      end
      for (int r = 0; r < 32; r++) mregs[r] = 32'h0;
      mstores.delete();
      mgpio = 8'h0;
      malu = 32'h0;
   endtask

   // instruction-level interpreter: architectural effects plus cycle cost
   task automatic model_run(input logic [31:0] stop, input int w);
      logic [31:0] pc, npc, insn, a, b, sx;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd;
      pc = RESET_PC;
      mcyc = 0;
      mtrap = 0;
      for (int n = 0; n < 1000; n++) begin
         if (pc == stop || mtrap) break;
         insn = mmem.exists(pc) ? mmem[pc] : 32'h0;
         op = insn[31:26]; rs = insn[25:21]; rt = insn[20:16]; rd = insn[15:11];
         fn = insn[5:0];
         sx = {{16{insn[15]}}, insn[15:0]};
         a = mregs[rs];
         b = mregs[rt];
         npc = pc + 32'd4;
         malu = npc + (sx << 2);
         case (op)
            6'h00: begin
               mcyc += 4 + w;
               case (fn)
                  6'h20: malu = a + b;
                  6'h22: malu = a - b;
                  6'h24: malu = a & b;
                  6'h25: malu = a | b;
                  6'h2A: malu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  default: mtrap = 1;
               endcase
               if (!mtrap && rd != 0) mregs[rd] = malu;
            end
            6'h08: begin
               mcyc += 4 + w;
               malu = a + sx;
               if (rt != 0) mregs[rt] = malu;
            end
            6'h23: begin
               mcyc += 5 + 2 * w;
               malu = a + sx;
               if (rt != 0) mregs[rt] = mmem.exists(malu) ? mmem[malu] : 32'h0;
            end
            6'h2B: begin
               malu = a + sx;
               if (malu == GPIO_ADDR) begin
                  mcyc += 4 + w;
                  mgpio = b[7:0];
               end else begin
                  mcyc += 4 + 2 * w;
                  mmem[malu] = b;
                  mstores.push_back({malu, b});
               end
            end
            6'h04: begin
               mcyc += 3 + w;
               if (a == b) npc = malu;
            end
`ifdef MIPS_MC_BNE_EN
            6'h05: begin
               mcyc += 3 + w;
               if (a != b) npc = malu;
            end
`endif
            6'h02: begin
               mcyc += 3 + w;
               npc = {npc[31:28], insn[25:0], 2'b00};
            end
            default: mtrap = 1;
         endcase
         if (!mtrap) pc = npc;
      end
   endtask

   // run until the core starts fetching target; advance skips the current cycle
   task automatic run_until(input logic [31:0] target, input bit advance, input int max_c);
      int start;
      bit first;
      start = cyc;
      first = advance;
      reached = 0;
      for (int k = 0; k < max_c; k++) begin
         if (!first && state == 4'd0 && mif.mem_req && mif.mem_addr == target) begin
            reached = 1;
            break;
         end
         first = 0;
         tick();
      end
      ran = cyc - start;
      check("reach_target", 32'(reached), 32'd1);
   endtask

   task automatic compare_model(input string tag);
      check({tag, "_cycles"}, 32'(cyc), 32'(mcyc));
      check({tag, "_gpio"}, 32'(gpio), 32'(mgpio));
      check({tag, "_result"}, result, malu);
      check({tag, "_nstores"}, 32'(stores.size()), 32'(mstores.size()));
      for (int i = 0; i < stores.size() && i < mstores.size(); i++) begin
         check({tag, "_st_addr"}, stores[i][63:32], mstores[i][63:32]);
         check({tag, "_st_data"}, stores[i][31:0], mstores[i][31:0]);
      end
   endtask

   task automatic trap_test(input string tag, input logic [31:0] insn);
      int reqs;
      prog.delete();
      prog.push_back(insn);
      load_prog();
      wait_n = 0;
      do_reset();
      for (int k = 0; k < 3; k++) tick();
      reqs = 0;
      for (int k = 0; k < 6; k++) begin
         if (mif.mem_req) reqs++;
         tick();
      end
      check({tag, "_noreq"}, 32'(reqs), 32'd0);
      check({tag, "_state"}, 32'(state), 32'd12);
      check({tag, "_trap"}, 32'(trap), 32'd1);
      do_reset();
      check({tag, "_rst_state"}, 32'(state), 32'd0);
      check({tag, "_rst_trap"}, 32'(trap), 32'd0);
      check({tag, "_rst_pc"}, mif.mem_addr, RESET_PC);
      check({tag, "_rst_req"}, 32'(mif.mem_req), 32'd1);
   endtask

   initial begin
      int t0, t1, lw_cyc, rs, rt, rd, gr;
      mif.mem_ready = 1'b0;
      mif.mem_rdata = 32'h0;
      @(negedge clk);

      // reset state
      reset = 1'b1;
      tick();
      tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_trap", 32'(trap), 32'd0);
      check("rst_gpio", 32'(gpio), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_req", 32'(mif.mem_req), 32'd0);

      // addi/addi/add with zero-wait memory
      prog = '{i_t(6'h08, 0, 8, 16'd5), i_t(6'h08, 0, 9, 16'd7), r_t(8, 9, 10, 6'h20)};
      load_prog();
      wait_n = 0;
      model_run(RESET_PC + 32'd12, 0);
      do_reset();
      run_until(RESET_PC + 32'd12, 0, 200);
      check("A_cycles", 32'(ran), 32'd12);
      check("A_result", result, 32'd12);
      check("A_pc", mif.mem_addr, RESET_PC + 32'd12);
      compare_model("A");
      $display("step A: add chain cycles=%0d result=%h", ran, result);

      // GPIO store
      prog.push_back(i_t(6'h23, 0, 11, 16'h0100));
      prog.push_back(i_t(6'h2B, 11, 10, 16'h0000));
      load_prog();
      model_run(RESET_PC + 32'd20, 0);
      do_reset();
      run_until(RESET_PC + 32'd20, 0, 200);
      check("B_cycles", 32'(ran), 32'd21);
      check("B_gpio", 32'(gpio), 32'h0C);
      check("B_bus_hits", 32'(gpio_bus_hits), 32'd0);
      compare_model("B");
      $display("step B: gpio store gpio=%h cycles=%0d", gpio, ran);

      // sw/lw round trip with 3 wait cycles per access
      prog = '{i_t(6'h08, 0, 8, 16'd5), i_t(6'h08, 0, 9, 16'd7), r_t(8, 9, 10, 6'h20),
               i_t(6'h23, 0, 12, 16'h0104), i_t(6'h2B, 12, 10, 16'h0000),
               i_t(6'h23, 12, 13, 16'h0000), r_t(13, 0, 14, 6'h20)};
      load_prog();
      wait_n = 3;
      model_run(RESET_PC + 32'd28, 3);
      do_reset();
      run_until(RESET_PC + 32'd20, 0, 400);
      t0 = ran;
      run_until(RESET_PC + 32'd24, 0, 400);
      lw_cyc = ran;
      run_until(RESET_PC + 32'd28, 0, 400);
      check("C_lw_cycles", 32'(lw_cyc), 32'd11);
      check("C_result", result, 32'd12);
      check("C_mem", mem.exists(DATA_BASE) ? mem[DATA_BASE] : 32'h0, 32'd12);
      compare_model("C");
      $display("step C: roundtrip lw_cycles=%0d total=%0d result=%h", lw_cyc, t0 + lw_cyc + ran, result);

      // beq loop
      prog = '{i_t(6'h08, 0, 8, 16'd5), i_t(6'h04, 8, 8, 16'hFFFF)};
      load_prog();
      wait_n = 0;
      do_reset();
      run_until(RESET_PC + 32'd4, 0, 100);
      check("D_first", 32'(ran), 32'd4);
      for (int k = 0; k < 3; k++) begin
         run_until(RESET_PC + 32'd4, 1, 100);
         check("D_loop", 32'(ran), 32'd3);
      end
      $display("step D: beq loop period=%0d", ran);

      // bne with equal operands
      prog = '{i_t(6'h08, 0, 8, 16'd5), i_t(6'h05, 8, 8, 16'hFFFF), i_t(6'h08, 0, 9, 16'd1)};
      load_prog();
      do_reset();
`ifdef MIPS_MC_BNE_EN
      run_until(RESET_PC + 32'd8, 0, 100);
      check("bne_fall", 32'(ran), 32'd7);
`else
      for (int k = 0; k < 10; k++) tick();
      check("bne_trap_state", 32'(state), 32'd12);
      check("bne_trap", 32'(trap), 32'd1);
`endif
      $display("step bne: state=%0d trap=%0d", state, trap);

      // jump
      prog = '{j_t(RESET_PC + 32'h40)};
      load_prog();
      do_reset();
      run_until(RESET_PC + 32'h40, 0, 100);
      check("J_cycles", 32'(ran), 32'd3);
      $display("step J: jump cycles=%0d", ran);

      trap_test("trap_op3f", 32'hFC00_0000);
      $display("step E1: opcode 0x3F trap checked");
      trap_test("trap_fn01", r_t(8, 9, 10, 6'h01));
      $display("step E2: funct 0x01 trap checked");

      // reset while a load is stalled
      prog = '{i_t(6'h08, 0, 10, 16'd12), i_t(6'h23, 0, 11, 16'h0100)};
      load_prog();
      wait_n = 10;
      do_reset();
      t1 = 0;
      for (int k = 0; k < 100 && state != 4'd3; k++) tick();
      check("F_in_memrd", 32'(state), 32'd3);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("F_req_in_reset", 32'(mif.mem_req), 32'd0);
      tick();
      check("F_state", 32'(state), 32'd0);
      check("F_req", 32'(mif.mem_req), 32'd0);
      check("F_result", result, 32'd0);
      prog = '{r_t(10, 0, 14, 6'h20)};
      load_prog();
      wait_n = 0;
      model_run(RESET_PC + 32'd4, 0);
      release_reset();
      run_until(RESET_PC + 32'd4, 0, 100);
      check("F_reg_cleared", result, 32'd0);
      compare_model("F");
      $display("step F: reset mid-load result=%h", result);

      // randomized programs
      for (int it = 0; it < 8; it++) begin
         prog.delete();
         for (int k = 0; k < 10; k++) begin
            rs = $urandom_range(0, 7);
            rt = $urandom_range(0, 7);
            rd = $urandom_range(0, 7);
            if ($urandom_range(0, 2) != 0) prog.push_back(i_t(6'h08, rs, rd, 16'($urandom)));
            else prog.push_back(r_t(rs, rt, rd, fns[$urandom_range(0, 4)]));
         end
         prog.push_back(i_t(6'h23, 0, 8, 16'h0104));
         for (int r = 1; r < 8; r++) prog.push_back(i_t(6'h2B, 8, r, 16'(4 * r)));
         gr = $urandom_range(1, 7);
         prog.push_back(i_t(6'h2B, 8, gr, 16'h0024));
         load_prog();
         wait_n = $urandom_range(0, 2);
         model_run(RESET_PC + 32'(4 * prog.size()), wait_n);
         do_reset();
         run_until(RESET_PC + 32'(4 * prog.size()), 0, 2000);
         compare_model("R");
         $display("step R%0d: wait=%0d cycles=%0d gpio=%h stores=%0d", it, wait_n, cyc, gpio,
                  stores.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
